imem_loader: RTL and testbench

Instruction-memory front end that sits directly upstream of `pcpu`. It accepts a program as 16-bit words over a valid/ready load port and writes them into a 256×16 instruction store. It then answers `pcpu` instruction fetches (`iAddr` → `iData`, wired to `pcpu.iDataIn`) and sequences `pcpu`'s `enable`/`start` so a freshly loaded program begins cleanly from address 0.

---
 rtl/imem_loader.sv | 156 +++++++++++++++
 tb/tb_imem_loader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: instruction-memory front end for pcpu.
//
// Accepts a program as WORD_W-bit words over a valid/ready load port, writes them into a
// 2^ADDR_W x WORD_W store starting at address 0, then answers pcpu fetches and sequences
// pcpu enable/start so a freshly loaded program begins cleanly from address 0.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   ldValid/ldData/ldLast load word handshake; ldLast marks the final word
//   ldReady               loader can accept a word (IDLE and LOAD)
//   runReq                start pcpu on current store contents without loading
//   stopReq               stop pcpu and return to idle
//   iAddr/iData           pcpu fetch port; iData is NOP (0) unless START or RUN
//   enable/start          to pcpu.enable / pcpu.start
//   loadCount             words accepted in the last/current load
//   overflow              last load filled the store without ldLast
//   busy                  high in every state except IDLE
//
// Build option: define IMEM_LOADER_HALT_FILL_EN to pad every unloaded address with HALT
// (16'h0800) after a short load, before the start pulse.

module imem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WORD_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ldValid,
  input  logic [WORD_W-1:0] ldData,
  input  logic              ldLast,
  output logic              ldReady,
  input  logic              runReq,
  input  logic              stopReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic [WORD_W-1:0] iData,
  output logic              enable,
  output logic              start,
  output logic [ADDR_W:0]   loadCount,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [WORD_W-1:0] HaltWord = WORD_W'(16'h0800);

`ifdef IMEM_LOADER_HALT_FILL_EN
  localparam bit FillEn = 1'b1;
`else
  localparam bit FillEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StLoad, StFill, StStart, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                mem_we;
  logic [WORD_W-1:0]   mem_wdata;
  logic [WORD_W-1:0]   mem_q [Depth];

  logic [ADDR_W-1:0]   wr_ptr_inc;
  logic                accept;
  state_e              post_load;

  assign wr_ptr_inc = wr_ptr_q + 1'b1;
  assign accept     = ldValid && ldReady;
  // After the final word: pad with HALT only if the load stopped short of a full wrap.
  assign post_load  = (FillEn && (wr_ptr_inc != '0)) ? StFill : StStart;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    mem_we    = 1'b0;
    mem_wdata = ldData;
    unique case (state_q)
      StIdle: begin
        // ldValid wins over runReq; wr_ptr is already 0 here.
        if (accept) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_inc;
          count_d  = {{ADDR_W{1'b0}}, 1'b1};
          ovf_d    = 1'b0;
          state_d  = ldLast ? post_load : StLoad;
        end else if (runReq) begin
          state_d = StStart;
        end
      end
      StLoad: begin
        if (accept) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_inc;
          count_d  = count_q + 1'b1;
          if (ldLast) begin
            state_d = post_load;
          end else if (wr_ptr_inc == '0) begin
            // Store full without a last marker: treat this word as last.
            ovf_d   = 1'b1;
            state_d = post_load;
          end
        end
      end
      StFill: begin
        mem_we    = 1'b1;
        mem_wdata = HaltWord;
        wr_ptr_d  = wr_ptr_inc;
        if (wr_ptr_inc == '0) begin
          state_d = StStart;
        end
      end
      StStart: begin
        // The start pulse always completes; stopReq only picks the next state.
        wr_ptr_d = '0;
        state_d  = stopReq ? StIdle : StRun;
      end
      StRun: begin
        if (stopReq) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Store contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= mem_wdata;
    end
  end

  assign ldReady   = (state_q == StIdle) || (state_q == StLoad);
  assign busy      = (state_q != StIdle);
  assign enable    = (state_q == StStart) || (state_q == StRun);
  assign start     = (state_q == StStart);
  assign loadCount = count_q;
  assign overflow  = ovf_q;
  assign iData     = enable ? mem_q[iAddr] : '0;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized loads/runs against a behavioural model
// (program image array plus a coarse phase variable), compared every cycle, plus literal
// expectations taken from worked examples.

module tb_imem_loader;

  localparam int DEPTH = 256;
  localparam int MIdle = 0, MLoad = 1, MFill = 2, MStart = 3, MRun = 4;
`ifdef IMEM_LOADER_HALT_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        ldValid, ldLast, ldReady, runReq, stopReq;
  logic [15:0] ldData, iData;
  logic [7:0]  iAddr;
  logic        enable, start, overflow, busy;
  logic [8:0]  loadCount;

  int checks = 0;
  int failures = 0;

  // Behavioural model
  int          m_mode = MIdle;
  int          m_cnt = 0;
  int          m_fill_left = 0;
  bit          m_ovf = 1'b0;
  logic [15:0] m_mem [DEPTH];
  bit          m_known [DEPTH];

  imem_loader #(.ADDR_W(8), .WORD_W(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .ldValid  (ldValid),
    .ldData   (ldData),
    .ldLast   (ldLast),
    .ldReady  (ldReady),
    .runReq   (runReq),
    .stopReq  (stopReq),
    .iAddr    (iAddr),
    .iData    (iData),
    .enable   (enable),
    .start    (start),
    .loadCount(loadCount),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int k;
    case (m_mode)
      MIdle, MLoad: begin
        if (ldValid) begin
          if (m_mode == MIdle) begin
            m_cnt = 0;
            m_ovf = 1'b0;
          end
          m_mem[m_cnt % DEPTH]   = ldData;
          m_known[m_cnt % DEPTH] = 1'b1;
          m_cnt++;
          if (ldLast || m_cnt == DEPTH) begin
            if (!ldLast) m_ovf = 1'b1;
            k = m_cnt % DEPTH;
            if (FILL && k != 0) begin
              m_mode      = MFill;
              m_fill_left = DEPTH - k;
            end else begin
              m_mode = MStart;
            end
          end else begin
            m_mode = MLoad;
          end
        end else if (m_mode == MIdle && runReq) begin
          m_mode = MStart;
        end
      end
      MFill: begin
        k = DEPTH - m_fill_left;
        m_mem[k]   = 16'h0800;
        m_known[k] = 1'b1;
        m_fill_left--;
        if (m_fill_left == 0) m_mode = MStart;
      end
      MStart: m_mode = stopReq ? MIdle : MRun;
      MRun:   if (stopReq) m_mode = MIdle;
      default: m_mode = MIdle;
    endcase
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_mode = MIdle;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_fill_left = 0;
      end else begin
        model_step();
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      chk("ldReady", 32'(ldReady), 32'(m_mode <= MLoad));
      chk("busy", 32'(busy), 32'(m_mode != MIdle));
      chk("enable", 32'(enable), 32'(m_mode >= MStart));
      chk("start", 32'(start), 32'(m_mode == MStart));
      chk("loadCount", 32'(loadCount), 32'(m_cnt));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (m_mode >= MStart) begin
        if (m_known[iAddr]) chk("iData", 32'(iData), 32'(m_mem[iAddr]));
      end else begin
        chk("iData_nop", 32'(iData), 32'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input bit last);
    ldValid = 1'b1;
    ldData  = d;
    ldLast  = last;
    tick();
    ldValid = 1'b0;
    ldLast  = 1'b0;
    ldData  = 16'($urandom);
  endtask

  task automatic wait_mode(input int mode, input int budget);
    int b = 0;
    while (m_mode != mode && b < budget) begin
      iAddr = 8'($urandom);
      tick();
      b++;
    end
    if (m_mode != mode) begin
      checks++;
      failures++;
      $display("FAIL wait_mode: got phase %0d expected %0d after %0d cycles", m_mode, mode, b);
    end
  endtask

  // Random program with ldValid gaps and ignored run/stop noise while in LOAD.
  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        repeat ($urandom_range(0, 2)) begin
          ldValid = 1'b0;
          ldData  = 16'($urandom);
          runReq  = 1'($urandom);
          stopReq = 1'($urandom);
          iAddr   = 8'($urandom);
          tick();
        end
      end
      runReq  = (i > 0) ? 1'($urandom) : 1'b0;
      stopReq = (i > 0) ? 1'($urandom) : 1'b0;
      iAddr   = 8'($urandom);
      send(16'($urandom), i == n - 1);
      runReq  = 1'b0;
      stopReq = 1'b0;
    end
  endtask

  task automatic stop_run();
    stopReq = 1'b1;
    tick();
    stopReq = 1'b0;
  endtask

  initial begin
    int fill_cycles;
    reset   = 1'b0;
    ldValid = 1'b0;
    ldData  = 16'h0;
    ldLast  = 1'b0;
    runReq  = 1'b0;
    stopReq = 1'b0;
    iAddr   = 8'h0;
    repeat (2) tick();
    chk("rst_ldReady", 32'(ldReady), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_loadCount", 32'(loadCount), 32'(0));
    chk("rst_iData", 32'(iData), 32'(0));
    reset = 1'b1;
    tick();

    // Three-word program.
    send(16'h1200, 1'b0);
    send(16'h4A01, 1'b0);
    send(16'h0800, 1'b1);
    if (FILL) begin
      fill_cycles = 0;
      while (!start && fill_cycles < 400) begin
        fill_cycles++;
        tick();
      end
      chk("fill_len", 32'(fill_cycles), 32'(253));
    end
    chk("p1_start", 32'(start), 32'(1));
    chk("p1_enable", 32'(enable), 32'(1));
    chk("p1_loadCount", 32'(loadCount), 32'(3));
    tick();
    chk("p1_run_start", 32'(start), 32'(0));
    chk("p1_run_enable", 32'(enable), 32'(1));
    iAddr = 8'd0; #1 chk("p1_i0", 32'(iData), 32'h1200);
    iAddr = 8'd1; #1 chk("p1_i1", 32'(iData), 32'h4A01);
    iAddr = 8'd2; #1 chk("p1_i2", 32'(iData), 32'h0800);
    if (FILL) begin
      iAddr = 8'hFF; #1 chk("p1_iFF_halt", 32'(iData), 32'h0800);
    end

    // Stop, then rerun the same program.
    stop_run();
    chk("stop_enable", 32'(enable), 32'(0));
    chk("stop_iData", 32'(iData), 32'(0));
    runReq = 1'b1;
    tick();
    runReq = 1'b0;
    chk("rerun_start", 32'(start), 32'(1));
    tick();
    iAddr = 8'd1; #1 chk("rerun_i1", 32'(iData), 32'h4A01);
    stop_run();

    // Randomized programs.
    for (int p = 0; p < 6; p++) begin
      load_random($urandom_range(1, 40));
      wait_mode(MRun, 400);
      repeat (12) begin
        iAddr = 8'($urandom);
        tick();
      end
      stop_run();
      // Rerun cancelled by a stop in the start cycle.
      runReq = 1'b1;
      tick();
      runReq  = 1'b0;
      stopReq = 1'b1;
      chk("stop_in_start_pulse", 32'(start), 32'(1));
      tick();
      stopReq = 1'b0;
      chk("stop_in_start_idle", 32'(busy), 32'(0));
    end

    // Overflow: 256 words, no ldLast.
    for (int i = 0; i < DEPTH; i++) begin
      if (i % 37 == 5) begin
        iAddr = 8'($urandom);
        tick();
      end
      send(16'(i) ^ 16'hA5A5, 1'b0);
    end
    chk("ovf_flag", 32'(overflow), 32'(1));
    chk("ovf_count", 32'(loadCount), 32'(256));
    chk("ovf_start", 32'(start), 32'(1));
    tick();
    iAddr = 8'hFF; #1 chk("ovf_iFF", 32'(iData), 32'hA55A);
    iAddr = 8'h00; #1 chk("ovf_i00", 32'(iData), 32'hA5A5);
    stop_run();

    // Reset in the middle of a load.
    for (int i = 0; i < 5; i++) send(16'($urandom), 1'b0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ldReady", 32'(ldReady), 32'(1));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_enable", 32'(enable), 32'(0));
    chk("mid_rst_start", 32'(start), 32'(0));
    chk("mid_rst_loadCount", 32'(loadCount), 32'(0));
    chk("mid_rst_overflow", 32'(overflow), 32'(0));
    chk("mid_rst_iData", 32'(iData), 32'(0));
    tick();
    reset = 1'b1;
    tick();
    send(16'h3C3C, 1'b0);
    send(16'h7E7E, 1'b1);
    wait_mode(MRun, 400);
    iAddr = 8'd0; #1 chk("reload_i0", 32'(iData), 32'h3C3C);
    iAddr = 8'd1; #1 chk("reload_i1", 32'(iData), 32'h7E7E);
    chk("reload_count", 32'(loadCount), 32'(2));
    stop_run();
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
